ipdom_warp_stack: RTL and testbench
===================================

// Module: ipdom_warp_stack
// PURPOSE
//  Multi-warp immediate-post-dominator (IPDOM) reconvergence stack for the SIMT
//  divergence unit. Holds one independent stack per warp in a single shared RAM.
//  Each entry carries two halves plus a "part" bit.
//  - First pop of an entry returns its q2 half (the deferred else-path).
//  - Second pop returns its q1 half (the reconvergence state) and frees the entry.
//  Adds per-warp pointers, a registered pop response, and error reporting.
// PARAMETERS
//  WIDTH      32  bits per half-entry (thread mask + PC, packed by caller)
//  DEPTH       8  entries per warp stack (>=2, power of two)
//  NUM_WARPS   4  number of warp stacks (>=1, power of two)
// PORTS
//  clk            in   1               clock
//  reset          in   1               asynchronous, active-high reset
//  push           in   1               push request
//  push_wid       in   log2(NUM_WARPS) warp id of push
//  push_q1        in   WIDTH           reconvergence half (returned second)
//  push_q2        in   WIDTH           else-path half (returned first)
//  pop            in   1               pop request
//  pop_wid        in   log2(NUM_WARPS) warp id of pop
//  rsp_valid      out  1               pop response valid (1 cycle after pop)
//  rsp_wid        out  log2(NUM_WARPS) warp id of response
//  rsp_data       out  WIDTH           popped half
//  rsp_last       out  1               1 = q1 half returned, entry freed
//  empty          out  NUM_WARPS       per-warp stack empty
//  full           out  NUM_WARPS       per-warp stack full
//  err_overflow   out  1               1-cycle pulse: push to a full warp, dropped
//  err_underflow  out  1               1-cycle pulse: pop of an empty warp, dropped
//  err_conflict   out  1               1-cycle pulse: push+pop same warp, pop dropped
// BEHAVIOUR
//  - Storage: RAM of NUM_WARPS*DEPTH x (2*WIDTH+1), addr = {wid, slot}.
//    Per-warp count sp[w] ranges 0..DEPTH; top-of-stack slot = sp[w]-1.
//    RAM data is not reset.
//  - Reset (async assert, sync release) clears: all sp and part bits, rsp_*,
//    err_*. Resulting outputs: empty = all 1s, full = all 0s.
//  - empty[w] = (sp[w]==0); full[w] = (sp[w]==DEPTH). Both are combinational from
//    registered sp and reflect state after the previous edge.
//  - Push (accepted iff !full[push_wid]) writes {q2,q1} at slot sp, sets part=0,
//    sp++. Push to a full warp: no state change, err_overflow next cycle.
//  - Pop (accepted iff !empty[pop_wid]) reads top entry.
//    - part==0: rsp_data=q2, rsp_last=0; set part=1; sp unchanged.
//    - part==1: rsp_data=q1, rsp_last=1; sp--.
//    Pop of an empty warp: no state change, no rsp_valid, err_underflow next cycle.
//  - Latency: rsp_valid/rsp_wid/rsp_data/rsp_last are registered and valid exactly
//    1 cycle after an accepted pop; held 0/stale otherwise (rsp_valid=0).
//  - Same-cycle push and pop:
//    - Different warps: both proceed independently. The RAM needs 1W+1R ports.
//    - Same warp: push proceeds, pop dropped, err_conflict pulses.
//  - Back-to-back pops of the same warp every cycle are supported. Part and sp
//    updates are visible to the next cycle's pop; no bubbles.
//  - A push to warp w in cycle N followed by a pop of w in N+1 returns the pushed
//    q2 (write-to-read bypass required).
//  - Reset mid-operation: an in-flight response is squashed (rsp_valid=0
//    immediately). All stacks become empty.
//  - No wrap-around: sp saturates by rejection at 0 and DEPTH. Counters are
//    log2(DEPTH)+1 bits wide.
// TESTING
//  - Reset -> empty=4'hF, full=0, rsp_valid=0, all err_* = 0.
//  - Warp 2: push(q1=A1,q2=A2), then pop, pop -> rsp A2 last=0, then A1 last=1;
//    empty[2]=1 after.
//  - Warp 1: push 8 entries (full[1]=1), 9th push -> err_overflow pulse.
//    Pop 16 -> halves return in LIFO order; 17th pop -> err_underflow, no rsp.
//  - Same cycle: push w0 + pop w3 (w3 has 1 entry) -> both succeed, rsp_wid=3.
//    Push w0 + pop w0 -> push kept, err_conflict=1, no rsp.
//  - Push w0 at cycle N, pop w0 at N+1 -> rsp_data at N+2 equals pushed q2
//    (bypass check).
//  - Assert reset one cycle after pop issue -> rsp_valid stays 0, all empty=1,
//    subsequent push/pop works.

Source files
------------

// File: rtl/ipdom_warp_stack.sv
`default_nettype none
// ============================================================================
// Module      : ipdom_warp_stack
// Description : Multi-warp IPDOM reconvergence stack. One LIFO per warp lives
//               in a shared RAM. Each entry holds an else-path half (q2) and a
//               reconvergence half (q1). The first pop of an entry returns q2;
//               the second pop returns q1 and frees the entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ipdom_warp_stack #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int NUM_WARPS = 4,
  localparam int c_WID_W  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [c_WID_W-1:0]   push_wid,
  input  logic [WIDTH-1:0]     push_q1,
  input  logic [WIDTH-1:0]     push_q2,
  input  logic                 pop,
  input  logic [c_WID_W-1:0]   pop_wid,
  output logic                 rsp_valid,
  output logic [c_WID_W-1:0]   rsp_wid,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_last,
  output logic [NUM_WARPS-1:0] empty,
  output logic [NUM_WARPS-1:0] full,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_conflict
);

  localparam int c_SLOT_W  = $clog2(DEPTH);
  localparam int c_SP_W    = c_SLOT_W + 1;
  localparam int c_ADDR_W  = c_WID_W + c_SLOT_W;
  localparam int c_ENTRIES = 1 << c_ADDR_W;

  // Per-warp entry counts; top-of-stack slot is count-1.
  logic [c_SP_W-1:0]    r_sp [NUM_WARPS];
  // Part bit per RAM entry: 0 = q2 still pending, 1 = only q1 remains.
  logic [c_ENTRIES-1:0] r_part;
  // Data RAM, {q2, q1}; not reset.
  logic [2*WIDTH-1:0]   r_mem [c_ENTRIES];

  logic [c_SP_W-1:0]    w_push_sp;
  logic [c_SP_W-1:0]    w_pop_sp;
  logic                 w_push_full;
  logic                 w_pop_empty;
  logic                 w_conflict;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic [c_SLOT_W-1:0]  w_pop_slot;
  logic [c_ADDR_W-1:0]  w_push_addr;
  logic [c_ADDR_W-1:0]  w_pop_addr;
  logic                 w_pop_part;
  logic [2*WIDTH-1:0]   w_pop_word;

  assign w_push_sp   = r_sp[push_wid];
  assign w_pop_sp    = r_sp[pop_wid];
  assign w_push_full = (w_push_sp == c_SP_W'(DEPTH));
  assign w_pop_empty = (w_pop_sp == '0);

  // A pop colliding with a push on the same warp is dropped; the push wins.
  assign w_conflict  = push && pop && (push_wid == pop_wid);
  assign w_push_ok   = push && !w_push_full;
  assign w_pop_ok    = pop && !w_conflict && !w_pop_empty;

  assign w_push_addr = {push_wid, w_push_sp[c_SLOT_W-1:0]};
  assign w_pop_slot  = w_pop_sp[c_SLOT_W-1:0] - c_SLOT_W'(1);
  assign w_pop_addr  = {pop_wid, w_pop_slot};

  // Asynchronous read: a write committed at the previous edge is already
  // visible here, which gives push-then-pop its bypass for free.
  assign w_pop_part  = r_part[w_pop_addr];
  assign w_pop_word  = r_mem[w_pop_addr];

  // Combinational per-warp status derived from the registered counts.
  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_flags
    assign empty[g] = (r_sp[g] == '0);
    assign full[g]  = (r_sp[g] == c_SP_W'(DEPTH));
  end

  // Stack pointers and part bits; accepted push and pop always hit different warps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_sp[w] <= '0;
      end
      r_part <= '0;
    end else begin
      if (w_push_ok) begin
        r_sp[push_wid]      <= w_push_sp + c_SP_W'(1);
        r_part[w_push_addr] <= 1'b0;
      end
      if (w_pop_ok) begin
        if (w_pop_part) begin
          r_sp[pop_wid] <= w_pop_sp - c_SP_W'(1);
        end else begin
          r_part[w_pop_addr] <= 1'b1;
        end
      end
    end
  end

  // Data RAM write port.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_push_addr] <= {push_q2, push_q1};
    end
  end

  // Registered pop response and single-cycle error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid     <= 1'b0;
      rsp_wid       <= '0;
      rsp_data      <= '0;
      rsp_last      <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_conflict  <= 1'b0;
    end else begin
      rsp_valid     <= w_pop_ok;
      err_overflow  <= push && w_push_full;
      err_underflow <= pop && !w_conflict && w_pop_empty;
      err_conflict  <= w_conflict;
      if (w_pop_ok) begin
        rsp_wid  <= pop_wid;
        rsp_data <= w_pop_part ? w_pop_word[WIDTH-1:0] : w_pop_word[2*WIDTH-1:WIDTH];
        rsp_last <= w_pop_part;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ipdom_warp_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipdom_warp_stack
// Description : Self-checking bench for ipdom_warp_stack. Directed scenarios
//               followed by random push/pop traffic, all compared against a
//               per-warp queue model of the stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipdom_warp_stack;

  localparam int c_WIDTH = 32;
  localparam int c_DEPTH = 8;
  localparam int c_NW    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              push = 1'b0;
  logic [1:0]        push_wid = '0;
  logic [31:0]       push_q1 = '0;
  logic [31:0]       push_q2 = '0;
  logic              pop = 1'b0;
  logic [1:0]        pop_wid = '0;
  logic              rsp_valid;
  logic [1:0]        rsp_wid;
  logic [31:0]       rsp_data;
  logic              rsp_last;
  logic [3:0]        empty;
  logic [3:0]        full;
  logic              err_overflow;
  logic              err_underflow;
  logic              err_conflict;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: each warp is a queue of entries; back of queue is top of stack.
  typedef struct {
    logic [31:0] q1;
    logic [31:0] q2;
    bit          half_taken;
  } ent_t;
  ent_t stk[c_NW][$];

  ipdom_warp_stack #(
    .WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .NUM_WARPS(c_NW)
  ) dut (
    .clk(clk), .reset(reset),
    .push(push), .push_wid(push_wid), .push_q1(push_q1), .push_q2(push_q2),
    .pop(pop), .pop_wid(pop_wid),
    .rsp_valid(rsp_valid), .rsp_wid(rsp_wid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .empty(empty), .full(full),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_conflict(err_conflict)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_flags();
    logic [3:0] e_empty, e_full;
    for (int w = 0; w < c_NW; w++) begin
      e_empty[w] = (stk[w].size() == 0);
      e_full[w]  = (stk[w].size() == c_DEPTH);
    end
    check("empty", 64'(empty), 64'(e_empty));
    check("full",  64'(full),  64'(e_full));
  endtask

  // One clock cycle: drive request, predict from model, sample after edge.
  task automatic step(input bit p, input int pw, input logic [31:0] a1, input logic [31:0] a2,
                      input bit o, input int ow);
    bit          conflict, ovf, und, pok, ook;
    logic [31:0] e_data;
    bit          e_last;
    ent_t        t;
    push = p; push_wid = pw[1:0]; push_q1 = a1; push_q2 = a2;
    pop  = o; pop_wid  = ow[1:0];
    conflict = p && o && (pw == ow);
    ovf      = p && (stk[pw].size() == c_DEPTH);
    pok      = p && !ovf;
    und      = o && !conflict && (stk[ow].size() == 0);
    ook      = o && !conflict && !und;
    e_data   = '0;
    e_last   = 1'b0;
    if (ook) begin
      t = stk[ow].pop_back();
      if (!t.half_taken) begin
        e_data = t.q2;
        e_last = 1'b0;
        t.half_taken = 1'b1;
        stk[ow].push_back(t);
      end else begin
        e_data = t.q1;
        e_last = 1'b1;
      end
    end
    if (pok) begin
      t.q1 = a1; t.q2 = a2; t.half_taken = 1'b0;
      stk[pw].push_back(t);
    end
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    check("rsp_valid", 64'(rsp_valid), 64'(ook));
    if (ook) begin
      check("rsp_wid",  64'(rsp_wid),  64'(ow[1:0]));
      check("rsp_data", 64'(rsp_data), 64'(e_data));
      check("rsp_last", 64'(rsp_last), 64'(e_last));
    end
    check("err_overflow",  64'(err_overflow),  64'(ovf));
    check("err_underflow", 64'(err_underflow), 64'(und));
    check("err_conflict",  64'(err_conflict),  64'(conflict));
    check_flags();
  endtask

  task automatic idle();
    step(1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  task automatic clear_model();
    for (int w = 0; w < c_NW; w++) stk[w].delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_empty"},     64'(empty),     64'hF);
    check({tag, "_full"},      64'(full),      64'h0);
    check({tag, "_errs"},      64'({err_overflow, err_underflow, err_conflict}), 64'd0);
  endtask

  // Asynchronous assert at a non-edge time, synchronous-side release after two edges.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    clear_model();
    check_reset_state(tag);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state({tag, "_rel"});
  endtask

  initial begin
    logic [31:0] d1, d2;
    int          pw, ow;
    bit          p, o;

    #1;
    do_reset("rst0");

    // Warp 2: single entry, two pops return q2 then q1.
    step(1'b1, 2, 32'hA1A1_0001, 32'hA2A2_0002, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 2);
    check("w2_q2", 64'(rsp_data), 64'hA2A2_0002);
    step(1'b0, 0, '0, '0, 1'b1, 2);
    check("w2_q1", 64'(rsp_data), 64'hA1A1_0001);
    check("w2_last", 64'(rsp_last), 64'd1);
    check("w2_empty", 64'(empty[2]), 64'd1);

    // Warp 1: fill, overflow, then drain fully in back-to-back pops and underflow.
    for (int i = 0; i < c_DEPTH; i++) step(1'b1, 1, 32'h1000 + i, 32'h2000 + i, 1'b0, 0);
    check("w1_full", 64'(full[1]), 64'd1);
    step(1'b1, 1, 32'hDEAD, 32'hBEEF, 1'b0, 0);
    check("w1_ovf", 64'(err_overflow), 64'd1);
    for (int i = 0; i < 2 * c_DEPTH; i++) step(1'b0, 0, '0, '0, 1'b1, 1);
    step(1'b0, 0, '0, '0, 1'b1, 1);
    check("w1_und", 64'(err_underflow), 64'd1);
    idle();

    // Same-cycle push/pop on different and on the same warp.
    step(1'b1, 3, 32'h3333_0001, 32'h3333_0002, 1'b0, 0);
    step(1'b1, 0, 32'h0000_00A1, 32'h0000_00A2, 1'b1, 3);
    check("diff_wid", 64'(rsp_wid), 64'd3);
    step(1'b1, 0, 32'h0000_00B1, 32'h0000_00B2, 1'b1, 0);
    check("same_conflict", 64'(err_conflict), 64'd1);

    // Bypass: push then immediate pop returns the just-written q2.
    step(1'b1, 0, 32'hC0C0_0001, 32'hC0C0_0002, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 0);
    check("bypass_q2", 64'(rsp_data), 64'hC0C0_0002);

    // Reset with a response in flight squashes it immediately.
    step(1'b0, 0, '0, '0, 1'b1, 0);
    do_reset("rst_mid");
    step(1'b1, 1, 32'h5555_0001, 32'h5555_0002, 1'b0, 0);
    step(1'b0, 0, '0, '0, 1'b1, 1);
    check("post_rst_q2", 64'(rsp_data), 64'h5555_0002);

    // Random traffic: push-heavy phase then pop-heavy phase.
    for (int n = 0; n < 3000; n++) begin
      p  = ($urandom_range(0, 99) < ((n < 1500) ? 60 : 30));
      o  = ($urandom_range(0, 99) < ((n < 1500) ? 45 : 75));
      pw = $urandom_range(0, c_NW - 1);
      ow = $urandom_range(0, c_NW - 1);
      d1 = $urandom;
      d2 = $urandom;
      step(p, pw, d1, d2, o, ow);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
